multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath; one instruction takes 2-5 states.
//  Drives the existing datapath control fields and strobes from the IR opcode/funct:
//    NPCOp, WDSel, WRSel, ExtOp, ALUOp, ALUSrc, Mem_type, RFWr, DMWr.
//  Adds PC/IR write strobes and a req/ready handshake to one unified memory port.
//  Instruction set: R-type (addu, subu, and, or, sll, sllv, jr, jalr), ori, addiu, lui,
//    lw/lh/lb, sw/sh/sb, beq, j, jal, bltzal.
// PARAMETERS
//  TO_W     8    width of the memory-wait timeout counter
//  TIMEOUT  200  cycles mem_req may stay unanswered before trapping (< 2**TO_W)
// PORTS
//  clk       in   1  clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  Opcode    in   6  IR[31:26]; stable from the cycle after IRWr
//  Funct     in   6  IR[5:0]
//  Zero      in   1  ALU zero flag (beq)
//  Branch    in   1  bltzal condition (rs < 0)
//  mem_ready in   1  memory completes the current request this cycle
//  mem_req   out  1  memory request, held until mem_ready
//  IorD      out  1  0 = address is PC (fetch), 1 = address is ALU result
//  IRWr      out  1  load IR (fetch-done cycle)
//  PCWr      out  1  update PC using NPCOp; exactly one pulse per instruction
//  NPCOp     out  2  00 = PC+4, 01 = branch, 10 = j/jal target, 11 = rs
//  WDSel     out  2  00 = ALU, 01 = memory, 10 = PC+4
//  WRSel     out  2  00 = rt, 01 = rd, 10 = $31
//  RFWr      out  1  register-file write strobe
//  ExtOp     out  2  00 = sign-extend, 01 = zero-extend, 10 = lui
//  ALUOp     out  3  000 = add, 001 = sub, 010 = and, 011 = or, 100 = shift
//  ALUSrc    out  1  0 = rt, 1 = immediate
//  DMWr      out  1  memory write (qualifies mem_req)
//  Mem_type  out  2  01 = byte, 10 = half, 11 = word
//  state     out  3  current state (debug)
//  trap      out  1  sticky: illegal instruction or memory timeout
// BEHAVIOUR
//  States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
//  Reset (async):
//    state = FETCH; all strobes 0 (mem_req, IRWr, PCWr, RFWr, DMWr); trap = 0;
//    NPCOp/WDSel/WRSel/ExtOp/ALUOp/ALUSrc/IorD = 0; Mem_type = 11.
//    First mem_req appears the cycle after rst_n deasserts.
//  Strobes are Moore-decoded from state plus the decoded instruction; they are 0 in every
//    state not listed below.
//  Mux fields are valid only while their state is active; they are don't-care elsewhere.
//  FETCH:
//    mem_req = 1, IorD = 0, DMWr = 0, Mem_type = 11.
//    On mem_ready: IRWr = 1 that cycle, then go to DECODE.
//  DECODE:
//    j: PCWr, NPCOp = 10, then FETCH.
//    jr: PCWr, NPCOp = 11, then FETCH.
//    jal/jalr/bltzal: go to WB.
//    Undefined opcode, or undefined funct under R-type: go to TRAP.
//    Everything else: go to EXEC.
//  EXEC:
//    ALUOp/ALUSrc/ExtOp follow the single-cycle decode.
//    beq: ALUOp = 001, PCWr, NPCOp = Zero ? 01 : 00, then FETCH.
//    Load/store: go to MEM. ALU and immediate instructions: go to WB.
//  MEM:
//    mem_req = 1, IorD = 1, Mem_type per opcode, DMWr = 1 for stores.
//    On mem_ready, loads go to WB.
//    On mem_ready, stores assert PCWr with NPCOp = 00 and go to FETCH.
//  WB (one cycle, always returns to FETCH):
//    ALU/immediate: RFWr = 1, WRSel = 01 for R-type else 00, WDSel = 00.
//    Loads: RFWr = 1, WRSel = 00, WDSel = 01.
//    jal: RFWr = 1, WRSel = 10, WDSel = 10, PCWr, NPCOp = 10.
//    jalr: RFWr = 1, WRSel = 01, WDSel = 10, PCWr, NPCOp = 11.
//    bltzal: RFWr = 1, WRSel = 10, WDSel = 10, PCWr, NPCOp = Branch ? 01 : 00.
//    ALU/immediate/load: PCWr, NPCOp = 00.
//  Handshake and timeout:
//    mem_req stays high and its address/type fields stay stable until mem_ready.
//    mem_ready while mem_req = 0 is ignored.
//    The wait counter clears on entry to FETCH or MEM and increments each waiting cycle.
//    Counter == TIMEOUT with no mem_ready: drop mem_req, set trap, go to TRAP.
//  TRAP: all strobes 0, trap = 1; leaves only on reset.
//  Reset mid-instruction abandons it; PC/RF are not written in that cycle.
// TESTING
//  addu $3,$1,$2, mem_ready=1 on 1st req: 4 cycles F,D,E,WB; RFWr/WRSel=01/PCWr only in WB.
//  lw, data mem_ready delayed 3 cycles: mem_req=1,IorD=1 held 4 cycles; 5+3 cycles total.
//  sb: DMWr=1,Mem_type=01 only in MEM; no RFWr pulse; PCWr=1 on ready cycle.
//  beq, Zero=1 -> PCWr,NPCOp=01 in EXEC; Zero=0 -> NPCOp=00; exactly one PCWr each.
//  jal -> F,D,WB with RFWr,WRSel=10,WDSel=10,NPCOp=10; j -> PCWr,NPCOp=10 in DECODE.
//  Opcode 6'b111111 -> TRAP, trap=1; hold mem_ready=0 201 cycles -> TRAP; rst_n=0 -> FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: walks FETCH/DECODE/EXEC/MEM/WB per instruction,
// drives datapath mux fields and strobes, and handshakes with one unified memory port.
module multicycle_ctrl #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Branch,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic [1:0] WDSel,
  output logic [1:0] WRSel,
  output logic       RFWr,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUOp,
  output logic       ALUSrc,
  output logic       DMWr,
  output logic [1:0] Mem_type,
  output logic [2:0] state,
  output logic       trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            trap_q, trap_d;
  logic            run_q, run_d;

  logic       is_rtype, is_alu_r, is_jr, is_jalr, is_ori, is_addiu, is_lui, is_imm;
  logic       is_load, is_store, is_beq, is_j, is_jal, is_bltzal, legal;
  logic [2:0] alu_op_dec;
  logic       alu_src_dec;
  logic [1:0] ext_op_dec, mem_type_dec;
  logic       waiting;

  always_comb begin
    is_rtype  = (Opcode == 6'b000000);
    is_alu_r  = is_rtype && (Funct inside {6'b100001, 6'b100011, 6'b100100,
                                          6'b100101, 6'b000000, 6'b000100});
    is_jr     = is_rtype && (Funct == 6'b001000);
    is_jalr   = is_rtype && (Funct == 6'b001001);
    is_ori    = (Opcode == 6'b001101);
    is_addiu  = (Opcode == 6'b001001);
    is_lui    = (Opcode == 6'b001111);
    is_imm    = is_ori || is_addiu || is_lui;
    is_load   = (Opcode inside {6'b100011, 6'b100001, 6'b100000});
    is_store  = (Opcode inside {6'b101011, 6'b101001, 6'b101000});
    is_beq    = (Opcode == 6'b000100);
    is_j      = (Opcode == 6'b000010);
    is_jal    = (Opcode == 6'b000011);
    is_bltzal = (Opcode == 6'b000001);
    legal     = is_alu_r || is_jr || is_jalr || is_imm || is_load || is_store ||
                is_beq || is_j || is_jal || is_bltzal;

    alu_op_dec  = 3'b000;
    alu_src_dec = 1'b0;
    ext_op_dec  = 2'b00;
    if (is_alu_r) begin
      case (Funct)
        6'b100011:            alu_op_dec = 3'b001;
        6'b100100:            alu_op_dec = 3'b010;
        6'b100101:            alu_op_dec = 3'b011;
        6'b000000, 6'b000100: alu_op_dec = 3'b100;
        default:              alu_op_dec = 3'b000;
      endcase
    end else if (is_beq) begin
      alu_op_dec = 3'b001;
    end else if (is_ori) begin
      alu_op_dec  = 3'b011;
      alu_src_dec = 1'b1;
      ext_op_dec  = 2'b01;
    end else if (is_lui) begin
      alu_src_dec = 1'b1;
      ext_op_dec  = 2'b10;
    end else if (is_addiu || is_load || is_store) begin
      alu_src_dec = 1'b1;
    end

    // Opcode[1:0] separates word (11), half (01) and byte (00) for both loads and stores
    case (Opcode[1:0])
      2'b01:   mem_type_dec = 2'b10;
      2'b00:   mem_type_dec = 2'b01;
      default: mem_type_dec = 2'b11;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trap_d   = trap_q;
    run_d    = 1'b1;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    NPCOp    = 2'b00;
    WDSel    = 2'b00;
    WRSel    = 2'b00;
    RFWr     = 1'b0;
    ExtOp    = 2'b00;
    ALUOp    = 3'b000;
    ALUSrc   = 1'b0;
    DMWr     = 1'b0;
    Mem_type = 2'b11;
    waiting  = (cnt_q != TIMEOUT_C);

    // ALU controls stay steady from DECODE through WB so the computed address holds
    if (state_q != S_FETCH && state_q != S_TRAP) begin
      ALUOp  = alu_op_dec;
      ALUSrc = alu_src_dec;
      ExtOp  = ext_op_dec;
    end

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          if (!waiting) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end else begin
            mem_req = 1'b1;
            if (mem_ready) begin
              IRWr    = 1'b1;
              state_d = S_DECODE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else if (is_j || is_jr) begin
          PCWr    = 1'b1;
          NPCOp   = is_j ? 2'b10 : 2'b11;
          state_d = S_FETCH;
        end else if (is_jal || is_jalr || is_bltzal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          PCWr    = 1'b1;
          NPCOp   = Zero ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        Mem_type = mem_type_dec;
        if (!waiting) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          DMWr    = is_store;
          if (mem_ready) begin
            if (is_store) begin
              PCWr    = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_WB: begin
        RFWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_FETCH;
        if (is_jal || is_bltzal) begin
          WRSel = 2'b10;
          WDSel = 2'b10;
          NPCOp = is_jal ? 2'b10 : (Branch ? 2'b01 : 2'b00);
        end else if (is_jalr) begin
          WRSel = 2'b01;
          WDSel = 2'b10;
          NPCOp = 2'b11;
        end else if (is_load) begin
          WDSel = 2'b01;
        end else if (is_alu_r) begin
          WRSel = 2'b01;
        end
      end
      S_TRAP: trap_d = 1'b1;
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
      end
    endcase

    // Any state change restarts the memory wait counter (covers entry to FETCH and MEM)
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      run_q   <= run_d;
    end
  end

  assign state = state_q;
  assign trap  = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds an expected per-cycle trace for each instruction
// from the instruction-class rules and compares every DUT output field each cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode, Funct;
  logic       Zero, Branch, mem_ready;
  logic       mem_req, IorD, IRWr, PCWr, RFWr, ALUSrc, DMWr, trap;
  logic [1:0] NPCOp, WDSel, WRSel, ExtOp, Mem_type;
  logic [2:0] ALUOp, state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TO_W(8), .TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Branch(Branch), .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
    .IRWr(IRWr), .PCWr(PCWr), .NPCOp(NPCOp), .WDSel(WDSel), .WRSel(WRSel),
    .RFWr(RFWr), .ExtOp(ExtOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .DMWr(DMWr),
    .Mem_type(Mem_type), .state(state), .trap(trap)
  );

  localparam int TIMEOUT = 200;

  typedef enum int {C_ALUR, C_IMM, C_LOAD, C_STORE, C_BEQ, C_J, C_JR,
                    C_JAL, C_JALR, C_BLTZAL, C_ILL} cls_t;

  typedef struct packed {
    logic       rstn, rdy, z, b;
    logic [5:0] op, fn;
    logic [2:0] st;
    logic       req, iord, irwr, pcwr, rfwr, dmwr, trap;
    logic [1:0] npc, wdsel, wrsel, ext, mtype;
    logic [2:0] aluop;
    logic       alusrc;
    logic       c_npc, c_wb, c_mem, c_alu, c_aluop, c_ext;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  logic cur_valid = 1'b0;
  int   tests = 0, fails = 0, cyc_no = 0, pcwr_cnt = 0, rfwr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h04: return C_ALUR;
               6'h08: return C_JR;
               6'h09: return C_JALR;
               default: return C_ILL;
             endcase
      6'h0d, 6'h09, 6'h0f: return C_IMM;
      6'h23, 6'h21, 6'h20: return C_LOAD;
      6'h2b, 6'h29, 6'h28: return C_STORE;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h01: return C_BLTZAL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [1:0] mtype_of(input logic [5:0] op);
    case (op)
      6'h23, 6'h2b: return 2'b11;
      6'h21, 6'h29: return 2'b10;
      default:      return 2'b01;
    endcase
  endfunction

  function automatic cyc_t base(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic b, input logic [2:0] st);
    cyc_t c;
    c       = '0;
    c.rstn  = 1'b1;
    c.op    = op;
    c.fn    = fn;
    c.z     = z;
    c.b     = b;
    c.st    = st;
    c.mtype = 2'b11;
    return c;
  endfunction

  // Two cycles held in reset, then the idle cycle before the first request.
  task automatic push_reset();
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = base(6'h00, 6'h00, 1'b0, 1'b0, 3'd0);
      c.rstn = (i == 2);
      c.c_npc = 1'b1; c.c_wb = 1'b1; c.c_mem = 1'b1;
      c.c_alu = 1'b1; c.c_aluop = 1'b1; c.c_ext = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic b, input int flat, input int mlat, input int keep,
                            output int n);
    cyc_t c;
    cls_t k;
    int   start;
    start = q.size();
    k = classify(op, fn);
    for (int i = 0; i <= flat; i++) begin
      c = base(op, fn, z, b, 3'd0);
      c.req = 1'b1; c.c_mem = 1'b1;
      c.rdy = (i == flat); c.irwr = (i == flat);
      q.push_back(c);
    end
    c = base(op, fn, z, b, 3'd1);
    if (k == C_J || k == C_JR) begin
      c.pcwr = 1'b1; c.c_npc = 1'b1;
      c.npc = (k == C_J) ? 2'b10 : 2'b11;
    end
    q.push_back(c);
    if (k == C_ILL) begin
      for (int i = 0; i < 3; i++) begin
        c = base(op, fn, z, b, 3'd7);
        c.trap = 1'b1; c.rdy = 1'b1;
        q.push_back(c);
      end
    end
    if (k inside {C_ALUR, C_IMM, C_LOAD, C_STORE, C_BEQ}) begin
      c = base(op, fn, z, b, 3'd2);
      c.c_alu = 1'b1;
      case (k)
        C_ALUR: begin
          c.c_aluop = 1'b1;
          case (fn)
            6'h21:   c.aluop = 3'd0;
            6'h23:   c.aluop = 3'd1;
            6'h24:   c.aluop = 3'd2;
            6'h25:   c.aluop = 3'd3;
            default: c.aluop = 3'd4;
          endcase
        end
        C_IMM: begin
          c.alusrc = 1'b1; c.c_ext = 1'b1;
          if (op == 6'h0d) begin c.aluop = 3'd3; c.ext = 2'b01; c.c_aluop = 1'b1; end
          else if (op == 6'h09) begin c.ext = 2'b00; c.c_aluop = 1'b1; end
          else c.ext = 2'b10;
        end
        C_BEQ: begin
          c.aluop = 3'd1; c.c_aluop = 1'b1;
          c.pcwr = 1'b1; c.c_npc = 1'b1; c.npc = z ? 2'b01 : 2'b00;
        end
        default: begin
          c.alusrc = 1'b1; c.c_aluop = 1'b1; c.c_ext = 1'b1;
        end
      endcase
      q.push_back(c);
    end
    if (k == C_LOAD || k == C_STORE) begin
      for (int i = 0; i <= mlat; i++) begin
        c = base(op, fn, z, b, 3'd3);
        c.req = 1'b1; c.iord = 1'b1; c.c_mem = 1'b1;
        c.dmwr = (k == C_STORE); c.mtype = mtype_of(op);
        c.rdy = (i == mlat);
        if (i == mlat && k == C_STORE) begin
          c.pcwr = 1'b1; c.c_npc = 1'b1; c.npc = 2'b00;
        end
        q.push_back(c);
      end
    end
    if (k inside {C_ALUR, C_IMM, C_LOAD, C_JAL, C_JALR, C_BLTZAL}) begin
      c = base(op, fn, z, b, 3'd4);
      c.rfwr = 1'b1; c.pcwr = 1'b1; c.c_npc = 1'b1; c.c_wb = 1'b1;
      case (k)
        C_ALUR:   c.wrsel = 2'b01;
        C_LOAD:   c.wdsel = 2'b01;
        C_JAL:    begin c.wrsel = 2'b10; c.wdsel = 2'b10; c.npc = 2'b10; end
        C_JALR:   begin c.wrsel = 2'b01; c.wdsel = 2'b10; c.npc = 2'b11; end
        C_BLTZAL: begin c.wrsel = 2'b10; c.wdsel = 2'b10; c.npc = b ? 2'b01 : 2'b00; end
        default:  ;
      endcase
      q.push_back(c);
    end
    if (keep > 0) begin
      while (q.size() - start > keep) q.delete(q.size() - 1);
    end
    n = q.size() - start;
  endtask

  // Fetch never answered: TIMEOUT cycles of request, one dropped cycle, then TRAP.
  task automatic push_timeout(input logic [5:0] op, input logic [5:0] fn);
    cyc_t c;
    for (int i = 0; i < TIMEOUT; i++) begin
      c = base(op, fn, 1'b0, 1'b0, 3'd0);
      c.req = 1'b1; c.c_mem = 1'b1;
      q.push_back(c);
    end
    q.push_back(base(op, fn, 1'b0, 1'b0, 3'd0));
    for (int i = 0; i < 3; i++) begin
      c = base(op, fn, 1'b0, 1'b0, 3'd7);
      c.trap = 1'b1; c.rdy = 1'b1;
      q.push_back(c);
    end
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("state", state, cur.st);
      chk("mem_req", mem_req, cur.req);
      chk("IRWr", IRWr, cur.irwr);
      chk("PCWr", PCWr, cur.pcwr);
      chk("RFWr", RFWr, cur.rfwr);
      chk("DMWr", DMWr, cur.dmwr);
      chk("trap", trap, cur.trap);
      if (cur.c_mem) begin
        chk("IorD", IorD, cur.iord);
        chk("Mem_type", Mem_type, cur.mtype);
      end
      if (cur.c_npc) chk("NPCOp", NPCOp, cur.npc);
      if (cur.c_wb) begin
        chk("WDSel", WDSel, cur.wdsel);
        chk("WRSel", WRSel, cur.wrsel);
      end
      if (cur.c_alu) chk("ALUSrc", ALUSrc, cur.alusrc);
      if (cur.c_aluop) chk("ALUOp", ALUOp, cur.aluop);
      if (cur.c_ext) chk("ExtOp", ExtOp, cur.ext);
      if (PCWr) pcwr_cnt++;
      if (RFWr) rfwr_cnt++;
      cyc_no++;
    end
  end

  initial begin
    int n_addu, n_lw, n_sb, n_beq, n_j, n_jal, n_tmp;
    rst_n = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0; Branch = 1'b0; mem_ready = 1'b0;

    push_reset();
    push_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, 0, 0, n_addu);  // addu
    push_instr(6'h00, 6'h23, 1'b0, 1'b0, 1, 0, 0, n_tmp);   // subu, slow fetch
    push_instr(6'h23, 6'h08, 1'b0, 1'b0, 0, 3, 0, n_lw);    // lw, data 3 late
    push_instr(6'h21, 6'h3f, 1'b0, 1'b0, 2, 0, 0, n_tmp);   // lh
    push_instr(6'h20, 6'h11, 1'b0, 1'b0, 0, 1, 0, n_tmp);   // lb
    push_instr(6'h2b, 6'h08, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // sw
    push_instr(6'h29, 6'h00, 1'b0, 1'b0, 0, 2, 0, n_tmp);   // sh
    push_instr(6'h28, 6'h2a, 1'b0, 1'b0, 0, 0, 0, n_sb);    // sb
    push_instr(6'h04, 6'h3f, 1'b1, 1'b0, 0, 0, 0, n_beq);   // beq taken
    push_instr(6'h04, 6'h3f, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // beq not taken
    push_instr(6'h02, 6'h15, 1'b0, 1'b0, 0, 0, 0, n_j);     // j
    push_instr(6'h00, 6'h08, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // jr
    push_instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0, 0, n_jal);   // jal
    push_instr(6'h00, 6'h09, 1'b0, 1'b0, 1, 0, 0, n_tmp);   // jalr
    push_instr(6'h01, 6'h00, 1'b0, 1'b1, 0, 0, 0, n_tmp);   // bltzal taken
    push_instr(6'h01, 6'h00, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // bltzal not taken
    push_instr(6'h0d, 6'h21, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // ori
    push_instr(6'h09, 6'h3c, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // addiu
    push_instr(6'h0f, 6'h00, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // lui
    push_instr(6'h00, 6'h24, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // and
    push_instr(6'h00, 6'h25, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // or
    push_instr(6'h00, 6'h00, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // sll
    push_instr(6'h00, 6'h04, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // sllv
    push_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, 0, 3, n_tmp);   // addu abandoned after EXEC
    push_reset();
    push_instr(6'h3f, 6'h00, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // illegal opcode
    push_reset();
    push_instr(6'h00, 6'h3f, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // illegal funct
    push_reset();
    push_timeout(6'h00, 6'h21);
    push_reset();
    push_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, 0, 0, n_tmp);   // recovery after reset

    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      cur       = q.pop_front();
      rst_n     = cur.rstn;
      mem_ready = cur.rdy;
      Zero      = cur.z;
      Branch    = cur.b;
      Opcode    = cur.op;
      Funct     = cur.fn;
      cur_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    cur_valid = 1'b0;

    chk("len_addu", n_addu, 4);
    chk("len_lw_late3", n_lw, 8);
    chk("len_sb", n_sb, 4);
    chk("len_beq", n_beq, 3);
    chk("len_j", n_j, 2);
    chk("len_jal", n_jal, 3);
    chk("pcwr_total", pcwr_cnt, 24);
    chk("rfwr_total", rfwr_cnt, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
